// File: rtl/dram_arbiter_if.sv
// Bundle of the three requester ports, the DRAM port and the streak observation signal.
// The slave modport is the arbiter side. The master modport is the requester/memory side.
interface dram_arbiter_if;
   logic        cpu_req;
   logic [20:0] cpu_addr;
   logic        cpu_we;
   logic        cpu_uds;
   logic        cpu_lds;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;

   logic        ica_as;
   logic [21:0] ica_adr;
   logic [15:0] ica_din;
   logic        ica_bus_ack;

   logic        file_as;
   logic [21:0] file_adr;
   logic [15:0] file_din;
   logic        file_bus_ack;

   logic        mem_req;
   logic [20:0] mem_addr;
   logic        mem_we;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   logic [7:0]  streak;

   modport slave (
      input  cpu_req, cpu_addr, cpu_we, cpu_uds, cpu_lds, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  ica_as, ica_adr,
      output ica_din, ica_bus_ack,
      input  file_as, file_adr,
      output file_din, file_bus_ack,
      output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      input  mem_rdata, mem_ack,
      output streak
   );

   modport master (
      output cpu_req, cpu_addr, cpu_we, cpu_uds, cpu_lds, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output ica_as, ica_adr,
      input  ica_din, ica_bus_ack,
      output file_as, file_adr,
      input  file_din, file_bus_ack,
      input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
      output mem_rdata, mem_ack,
      input  streak
   );
endinterface

// File: rtl/dram_arbiter.sv
// Serialises CPU, ICA and display-file accesses onto one 16-bit DRAM port.
// Video has priority. A bounded video streak lets a waiting CPU through.
module dram_arbiter #(
   parameter int unsigned MAX_VIDEO_STREAK = 8
) (
   input logic           clk,
   input logic           reset,
   dram_arbiter_if.slave bus_io
);

   localparam int unsigned StreakW = $clog2(MAX_VIDEO_STREAK + 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
   typedef enum logic [1:0] {GntCpu, GntIca, GntFile} gnt_e;

   state_e               state_q;
   gnt_e                 gnt_q;
   logic [StreakW-1:0]   streak_q;
   logic                 mem_req_q;
   logic [20:0]          mem_addr_q;
   logic                 mem_we_q;
   logic [1:0]           mem_be_q;
   logic [15:0]          mem_wdata_q;
   logic [15:0]          cpu_rdata_q;
   logic [15:0]          ica_din_q;
   logic [15:0]          file_din_q;
   logic                 cpu_ack_q;
   logic                 ica_ack_q;
   logic                 file_ack_q;

   logic                 cpu_elig;
   logic                 cpu_wins;
   logic [StreakW-1:0]   streak_video;

   always_comb begin
      cpu_elig = bus_io.cpu_req & (bus_io.cpu_uds | bus_io.cpu_lds);
      cpu_wins = cpu_elig &
                 (~(bus_io.file_as | bus_io.ica_as) ||
                  (streak_q == StreakW'(MAX_VIDEO_STREAK)));
      // Streak value after a video grant: counts only while the CPU is kept waiting.
      streak_video = '0;
      if (cpu_elig) begin
         streak_video = (streak_q == StreakW'(MAX_VIDEO_STREAK)) ? streak_q
                                                                  : streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         gnt_q       <= GntCpu;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 2'b00;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         ica_din_q   <= '0;
         file_din_q  <= '0;
         cpu_ack_q   <= 1'b0;
         ica_ack_q   <= 1'b0;
         file_ack_q  <= 1'b0;
      end else begin
         cpu_ack_q  <= 1'b0;
         ica_ack_q  <= 1'b0;
         file_ack_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cpu_wins) begin
                  gnt_q       <= GntCpu;
                  streak_q    <= '0;
                  mem_addr_q  <= bus_io.cpu_addr;
                  mem_we_q    <= bus_io.cpu_we;
                  mem_be_q    <= bus_io.cpu_we ? {bus_io.cpu_uds, bus_io.cpu_lds} : 2'b11;
                  mem_wdata_q <= bus_io.cpu_wdata;
                  mem_req_q   <= 1'b1;
                  state_q     <= StAccess;
               end else if (bus_io.file_as) begin
                  gnt_q       <= GntFile;
                  streak_q    <= streak_video;
                  mem_addr_q  <= 21'(bus_io.file_adr >> 1);
                  mem_we_q    <= 1'b0;
                  mem_be_q    <= 2'b11;
                  mem_wdata_q <= '0;
                  mem_req_q   <= 1'b1;
                  state_q     <= StAccess;
               end else if (bus_io.ica_as) begin
                  gnt_q       <= GntIca;
                  streak_q    <= streak_video;
                  mem_addr_q  <= 21'(bus_io.ica_adr >> 1);
                  mem_we_q    <= 1'b0;
                  mem_be_q    <= 2'b11;
                  mem_wdata_q <= '0;
                  mem_req_q   <= 1'b1;
                  state_q     <= StAccess;
               end else begin
                  streak_q <= '0;
               end
            end
            StAccess: begin
               if (bus_io.mem_ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= StDone;
                  unique case (gnt_q)
                     GntCpu: begin
                        if (!mem_we_q) cpu_rdata_q <= bus_io.mem_rdata;
                        cpu_ack_q <= 1'b1;
                     end
                     GntIca: begin
                        ica_din_q <= bus_io.mem_rdata;
                        ica_ack_q <= 1'b1;
                     end
                     GntFile: begin
                        file_din_q <= bus_io.mem_rdata;
                        file_ack_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.mem_req      = mem_req_q;
   assign bus_io.mem_addr     = mem_addr_q;
   assign bus_io.mem_we       = mem_we_q;
   assign bus_io.mem_be       = mem_be_q;
   assign bus_io.mem_wdata    = mem_wdata_q;
   assign bus_io.cpu_rdata    = cpu_rdata_q;
   assign bus_io.cpu_ack      = cpu_ack_q;
   assign bus_io.ica_din      = ica_din_q;
   assign bus_io.ica_bus_ack  = ica_ack_q;
   assign bus_io.file_din     = file_din_q;
   assign bus_io.file_bus_ack = file_ack_q;
   assign bus_io.streak       = 8'(streak_q);

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a queue of expected completions is filled
// as requests are issued and drained as ack pulses appear; a behavioural DRAM answers mem_req.
module tb_dram_arbiter;

   localparam int PCpu  = 0;
   localparam int PIca  = 1;
   localparam int PFile = 2;

   typedef struct {
      int          port;
      logic [15:0] data;
   } exp_t;

   logic clk;
   logic reset;

   dram_arbiter_if bus_if ();

   dram_arbiter #(
      .MAX_VIDEO_STREAK(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus_io(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int          n_cmp;
   int          n_err;
   int          mem_delay;
   int          wcnt;
   logic [15:0] last_cpu;

   function automatic logic [15:0] rd_val(input logic [20:0] a);
      return (a == 21'h000080) ? 16'hBEEF : (a[15:0] ^ 16'h3C5A);
   endfunction

   function automatic exp_t mk(input int port, input logic [15:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      return e;
   endfunction

   // One cycle: scoreboard any ack, then let the memory model react.
   task automatic tick();
      int          n_acks;
      int          obs_port;
      logic [15:0] obs_data;
      exp_t        e;
      @(negedge clk);
      n_acks = int'(bus_if.cpu_ack) + int'(bus_if.ica_bus_ack) + int'(bus_if.file_bus_ack);
      obs_port = bus_if.file_bus_ack ? PFile : (bus_if.ica_bus_ack ? PIca : PCpu);
      obs_data = bus_if.file_bus_ack ? bus_if.file_din :
                 (bus_if.ica_bus_ack ? bus_if.ica_din : bus_if.cpu_rdata);
      if (n_acks != 0) begin
         n_cmp++;
         if (n_acks > 1) begin
            n_err++;
            $display("FAIL simultaneous_acks: got %0d acks, expected 1", n_acks);
         end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ack: got ack on port %0d, expected none", obs_port);
         end else begin
            e = exp_q.pop_front();
            if (obs_port !== e.port || obs_data !== e.data) begin
               n_err++;
               $display("FAIL completion: got port %0d data %h, expected port %0d data %h",
                        obs_port, obs_data, e.port, e.data);
            end
         end
      end
      if (bus_if.mem_ack) begin
         bus_if.mem_ack = 1'b0;
         wcnt = 0;
      end else if (bus_if.mem_req) begin
         if (wcnt == mem_delay) begin
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = rd_val(bus_if.mem_addr);
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
         if (bus_if.cpu_ack)      bus_if.cpu_req = 1'b0;
         if (bus_if.ica_bus_ack)  bus_if.ica_as  = 1'b0;
         if (bus_if.file_bus_ack) bus_if.file_as = 1'b0;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_be, bus_if.cpu_ack, bus_if.ica_bus_ack,
           bus_if.file_bus_ack} !== 7'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, expected 0", {bus_if.mem_req, bus_if.mem_we,
                  bus_if.mem_be, bus_if.cpu_ack, bus_if.ica_bus_ack, bus_if.file_bus_ack});
      end
      n_cmp++;
      if (bus_if.mem_addr !== 21'd0) begin
         n_err++;
         $display("FAIL reset_addr: got %h, expected 0", bus_if.mem_addr);
      end
      n_cmp++;
      if (bus_if.mem_wdata !== 16'd0) begin
         n_err++;
         $display("FAIL reset_wdata: got %h, expected 0", bus_if.mem_wdata);
      end
      n_cmp++;
      if ({bus_if.cpu_rdata, bus_if.ica_din, bus_if.file_din} !== 48'd0) begin
         n_err++;
         $display("FAIL reset_data: got %h, expected 0",
                  {bus_if.cpu_rdata, bus_if.ica_din, bus_if.file_din});
      end
      n_cmp++;
      if (bus_if.streak !== 8'd0) begin
         n_err++;
         $display("FAIL reset_streak: got %0d, expected 0", bus_if.streak);
      end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single_ica();
      mem_delay = 0;
      exp_q.push_back(mk(PIca, 16'hBEEF));
      bus_if.ica_adr = 22'h000100;
      bus_if.ica_as  = 1'b1;
      tick();
      n_cmp++;
      if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 21'h000080) begin
         n_err++;
         $display("FAIL ica_cycle1: got req %b addr %h, expected req 1 addr 000080",
                  bus_if.mem_req, bus_if.mem_addr);
      end
      bus_if.ica_as = 1'b0;
      tick();
      n_cmp++;
      if (bus_if.ica_bus_ack !== 1'b1 || bus_if.ica_din !== 16'hBEEF) begin
         n_err++;
         $display("FAIL ica_cycle2: got ack %b din %h, expected ack 1 din beef",
                  bus_if.ica_bus_ack, bus_if.ica_din);
      end
      tick();
      n_cmp++;
      if (bus_if.ica_bus_ack !== 1'b0) begin
         n_err++;
         $display("FAIL ica_pulse: got ack %b in cycle 3, expected 0", bus_if.ica_bus_ack);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      mem_delay = 1;
      repeat (2) tick();
      exp_q.push_back(mk(PFile, rd_val(21'h001000)));
      exp_q.push_back(mk(PIca,  rd_val(21'h001801)));
      exp_q.push_back(mk(PCpu,  rd_val(21'h000055)));
      last_cpu = rd_val(21'h000055);
      bus_if.file_adr = 22'h002000;
      bus_if.ica_adr  = 22'h003003;
      bus_if.cpu_addr = 21'h000055;
      bus_if.cpu_we   = 1'b0;
      bus_if.cpu_uds  = 1'b1;
      bus_if.cpu_lds  = 1'b1;
      bus_if.file_as  = 1'b1;
      bus_if.ica_as   = 1'b1;
      bus_if.cpu_req  = 1'b1;
      drain(60);
   endtask

   task automatic test_cpu_write();
      mem_delay = 0;
      repeat (2) tick();
      exp_q.push_back(mk(PCpu, last_cpu));
      bus_if.cpu_addr  = 21'h000010;
      bus_if.cpu_we    = 1'b1;
      bus_if.cpu_uds   = 1'b0;
      bus_if.cpu_lds   = 1'b1;
      bus_if.cpu_wdata = 16'h12AB;
      bus_if.cpu_req   = 1'b1;
      tick();
      n_cmp++;
      if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_be} !== 4'b1101 ||
          bus_if.mem_wdata !== 16'h12AB || bus_if.mem_addr !== 21'h000010) begin
         n_err++;
         $display("FAIL cpu_write_bus: got req/we/be %b wdata %h addr %h, expected 1101 12ab 000010",
                  {bus_if.mem_req, bus_if.mem_we, bus_if.mem_be}, bus_if.mem_wdata,
                  bus_if.mem_addr);
      end
      bus_if.cpu_req = 1'b0;
      tick();
      n_cmp++;
      if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_rdata !== last_cpu) begin
         n_err++;
         $display("FAIL cpu_write_ack: got ack %b rdata %h, expected ack 1 rdata %h",
                  bus_if.cpu_ack, bus_if.cpu_rdata, last_cpu);
      end
      bus_if.cpu_we = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      int files;
      int cpus;
      int n;
      mem_delay = 0;
      repeat (2) tick();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) exp_q.push_back(mk(PFile, rd_val(21'h000020)));
         exp_q.push_back(mk(PCpu, rd_val(21'h000077)));
      end
      last_cpu = rd_val(21'h000077);
      bus_if.file_adr = 22'h000040;
      bus_if.cpu_addr = 21'h000077;
      bus_if.cpu_we   = 1'b0;
      bus_if.cpu_uds  = 1'b1;
      bus_if.cpu_lds  = 1'b1;
      bus_if.file_as  = 1'b1;
      bus_if.cpu_req  = 1'b1;
      files = 0;
      cpus  = 0;
      n     = 0;
      while (cpus < 2 && n < 300) begin
         tick();
         n++;
         if (bus_if.file_bus_ack) begin
            files++;
            if (files == 8) begin
               n_cmp++;
               if (bus_if.streak !== 8'd8) begin
                  n_err++;
                  $display("FAIL streak_full: got %0d, expected 8", bus_if.streak);
               end
            end
         end
         if (bus_if.cpu_ack) begin
            n_cmp++;
            if (files !== 8) begin
               n_err++;
               $display("FAIL starve_count: got %0d file grants, expected 8", files);
            end
            n_cmp++;
            if (bus_if.streak !== 8'd0) begin
               n_err++;
               $display("FAIL streak_clear: got %0d, expected 0", bus_if.streak);
            end
            files = 0;
            cpus++;
         end
      end
      bus_if.file_as = 1'b0;
      bus_if.cpu_req = 1'b0;
      if (cpus < 2 || exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL starve_timeout: got %0d cpu grants, expected 2", cpus);
         exp_q.delete();
      end
      tick();
   endtask

   task automatic test_no_enable();
      bit seen;
      repeat (2) tick();
      bus_if.cpu_addr = 21'h000033;
      bus_if.cpu_uds  = 1'b0;
      bus_if.cpu_lds  = 1'b0;
      bus_if.cpu_req  = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (bus_if.mem_req || bus_if.cpu_ack) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL no_enable: got activity %b, expected 0", seen);
      end
      bus_if.cpu_req = 1'b0;
   endtask

   task automatic test_wait_states();
      int c;
      bit stable;
      mem_delay = 5;
      repeat (2) tick();
      exp_q.push_back(mk(PIca, rd_val(21'h0091A5)));
      bus_if.ica_adr = 22'h01234A;
      bus_if.ica_as  = 1'b1;
      tick();
      bus_if.ica_as = 1'b0;
      c = 1;
      stable = 1'b1;
      while (!bus_if.ica_bus_ack && c < 20) begin
         if (bus_if.mem_req !== 1'b1 || bus_if.mem_addr !== 21'h0091A5) stable = 1'b0;
         tick();
         c++;
      end
      n_cmp++;
      if (stable !== 1'b1) begin
         n_err++;
         $display("FAIL wait_stable: got stable %b, expected 1", stable);
      end
      n_cmp++;
      if (c !== 7) begin
         n_err++;
         $display("FAIL wait_latency: got ack in cycle %0d, expected 7", c);
      end
      tick();
   endtask

   task automatic test_reset_mid_access();
      bit seen;
      mem_delay = 10;
      repeat (2) tick();
      bus_if.ica_adr = 22'h000200;
      bus_if.ica_as  = 1'b1;
      tick();
      bus_if.ica_as = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if (bus_if.mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_drop: got mem_req %b, expected 0", bus_if.mem_req);
      end
      reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (bus_if.ica_bus_ack || bus_if.mem_req) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abandon: got activity %b, expected 0", seen);
      end
      mem_delay = 0;
      exp_q.push_back(mk(PFile, rd_val(21'h000300)));
      bus_if.file_adr = 22'h000600;
      bus_if.file_as  = 1'b1;
      drain(20);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      mem_delay = 0;
      wcnt = 0;
      last_cpu = 16'h0000;
      reset = 1'b1;
      bus_if.cpu_req   = 1'b0;
      bus_if.cpu_addr  = '0;
      bus_if.cpu_we    = 1'b0;
      bus_if.cpu_uds   = 1'b0;
      bus_if.cpu_lds   = 1'b0;
      bus_if.cpu_wdata = '0;
      bus_if.ica_as    = 1'b0;
      bus_if.ica_adr   = '0;
      bus_if.file_as   = 1'b0;
      bus_if.file_adr  = '0;
      bus_if.mem_rdata = '0;
      bus_if.mem_ack   = 1'b0;

      test_reset();
      test_single_ica();
      test_simultaneous();
      test_cpu_write();
      test_starvation();
      test_no_enable();
      test_wait_states();
      test_reset_mid_access();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
